// File: rtl/fb_scanout.sv
// fb_scanout: 640x480@60 VGA scanout of a 2bpp 320x240 frame buffer, each buffer pixel
// drawn as a 2x2 block, with fixed palette, pixel-aligned syncs and a per-frame tick.
module fb_scanout #(
    parameter int FB_W       = 320,
    parameter int FB_H       = 240,
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 2,
    parameter int H_DISPLAY  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] dout_b,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  video_on,
    output logic [7:0]            rgb,
    output logic                  frame_tick
);
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    if (2 ** ADDR_WIDTH < FB_W * FB_H) begin : g_addr_check
        $error("ADDR_WIDTH too small for frame buffer");
    end

    logic                  p_tick;
    logic [HW-1:0]         h_cnt;
    logic [VW-1:0]         v_cnt;
    logic [ADDR_WIDTH-1:0] row_base;
    logic                  h_end, v_end, active;
    logic [7:0]            colour;

    assign h_end  = h_cnt == HW'(H_TOTAL - 1);
    assign v_end  = v_cnt == VW'(V_TOTAL - 1);
    assign active = (h_cnt < HW'(H_DISPLAY)) && (v_cnt < VW'(V_DISPLAY));
    assign addr_b = active ? row_base + ADDR_WIDTH'(h_cnt >> 1) : row_base;
    assign colour = dout_b == 2'd0 ? 8'h00 :
                    dout_b == 2'd1 ? 8'hFF :
                    dout_b == 2'd2 ? 8'h1C : 8'hE0;

    // dout_b seen on a tick edge belongs to the counter state that edge ends,
    // so all registered outputs describe the previous pixel together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_tick     <= 1'b0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            row_base   <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            video_on   <= 1'b0;
            rgb        <= 8'h00;
            frame_tick <= 1'b0;
        end else begin
            p_tick     <= !p_tick;
            frame_tick <= p_tick && h_end && v_cnt == VW'(V_DISPLAY - 1);
            if (p_tick) begin
                h_cnt    <= h_end ? '0 : h_cnt + HW'(1);
                video_on <= active;
                hsync    <= !(h_cnt >= HW'(H_DISPLAY + H_FP) && h_cnt < HW'(H_DISPLAY + H_FP + H_SYNC));
                vsync    <= !(v_cnt >= VW'(V_DISPLAY + V_FP) && v_cnt < VW'(V_DISPLAY + V_FP + V_SYNC));
                rgb      <= active ? colour : 8'h00;
                if (h_end) begin
                    v_cnt    <= v_end ? '0 : v_cnt + VW'(1);
                    row_base <= v_end ? '0 :
                                (v_cnt[0] && v_cnt < VW'(V_DISPLAY - 1)) ? row_base + ADDR_WIDTH'(FB_W) : row_base;
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: checks a full-size scanout and a shrunken-timing scanout against a
// position-based reference model fed by behavioural synchronous-read RAMs.
module tb_fb_scanout;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int hd[2]  = '{640, 16};
    int hf[2]  = '{16, 2};
    int hsw[2] = '{96, 3};
    int hb[2]  = '{48, 3};
    int vd[2]  = '{480, 12};
    int vf[2]  = '{10, 1};
    int vsw[2] = '{2, 2};
    int vb[2]  = '{33, 2};
    int fw[2]  = '{320, 8};

    logic [16:0] a0;
    logic [5:0]  a1;
    logic [1:0]  q0, q1;
    logic        hs0, vs0, vo0, ft0, hs1, vs1, vo1, ft1;
    logic [7:0]  rgb0, rgb1;
    logic [1:0]  mem0 [76800];
    logic [1:0]  mem1 [48];
    logic        rand_q = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    fb_scanout d0 (.clk(clk), .reset_n(reset_n), .addr_b(a0), .dout_b(q0), .hsync(hs0),
                   .vsync(vs0), .video_on(vo0), .rgb(rgb0), .frame_tick(ft0));

    fb_scanout #(.FB_W(8), .FB_H(6), .ADDR_WIDTH(6), .DATA_WIDTH(2),
                 .H_DISPLAY(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                 .V_DISPLAY(12), .V_FP(1), .V_SYNC(2), .V_BP(2))
        d1 (.clk(clk), .reset_n(reset_n), .addr_b(a1), .dout_b(q1), .hsync(hs1),
            .vsync(vs1), .video_on(vo1), .rgb(rgb1), .frame_tick(ft1));

    always @(posedge clk) begin
        q0 <= rand_q ? 2'($urandom) : mem0[a0];
        q1 <= rand_q ? 2'($urandom) : mem1[a1];
    end

    // k = pixel periods completed since reset release; lt = last edge was a pixel edge
    logic ph, lt;
    int   k;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph <= 1'b0;
            lt <= 1'b0;
            k  <= 0;
        end else begin
            lt <= ph;
            ph <= !ph;
            if (ph) k <= k + 1;
        end
    end

    localparam logic [28:0] RST_V = {17'd0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};

    logic [28:0] act0, act1;
    assign act0 = {a0, vo0, hs0, vs0, rgb0, ft0};
    assign act1 = {11'd0, a1, vo1, hs1, vs1, rgb1, ft1};

    function automatic logic [7:0] pal(input logic [1:0] d);
        return d == 2'd0 ? 8'h00 : d == 2'd1 ? 8'hFF : d == 2'd2 ? 8'h1C : 8'hE0;
    endfunction

    function automatic int addr_of(input int s, input int j);
        int ht, vt, h, v, rb;
        ht = hd[s] + hf[s] + hsw[s] + hb[s];
        vt = vd[s] + vf[s] + vsw[s] + vb[s];
        h  = j % ht;
        v  = (j / ht) % vt;
        rb = ((v < vd[s] ? v : vd[s] - 1) / 2) * fw[s];
        return (h < hd[s] && v < vd[s]) ? rb + h / 2 : rb;
    endfunction

    function automatic logic [28:0] expv(input int s);
        int ht, vt, j, h, v;
        logic vo, hs, vs, ft;
        logic [1:0] d;
        logic [7:0] c;
        if (k == 0) return RST_V;
        ht = hd[s] + hf[s] + hsw[s] + hb[s];
        vt = vd[s] + vf[s] + vsw[s] + vb[s];
        j  = k - 1;
        h  = j % ht;
        v  = (j / ht) % vt;
        vo = h < hd[s] && v < vd[s];
        hs = !(h >= hd[s] + hf[s] && h < hd[s] + hf[s] + hsw[s]);
        vs = !(v >= vd[s] + vf[s] && v < vd[s] + vf[s] + vsw[s]);
        d  = s == 1 ? mem1[addr_of(1, j)] : mem0[addr_of(0, j)];
        c  = vo ? pal(d) : 8'h00;
        ft = lt && h == ht - 1 && v == vd[s] - 1;
        return {17'(addr_of(s, k)), vo, hs, vs, c, ft};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rand_q  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            n_tests += 2;
            if (act0 !== RST_V) begin
                n_fail++;
                $display("FAIL reset_d0 act=%h exp=%h", act0, RST_V);
            end
            if (act1 !== RST_V) begin
                n_fail++;
                $display("FAIL reset_d1 act=%h exp=%h", act1, RST_V);
            end
        end
        rand_q = 1'b0;
    endtask

    task automatic test_first_lines();
        for (int i = 0; i < 76800; i++) mem0[i] = 2'(i);
        for (int i = 0; i < 48; i++) mem1[i] = 2'($urandom);
        do_reset();
        repeat (3 * 1600 + 4) begin
            @(negedge clk);
            n_tests += 2;
            if (act0 !== expv(0)) begin
                n_fail++;
                $display("FAIL lines_d0 k=%0d act=%h exp=%h", k, act0, expv(0));
            end
            if (act1 !== expv(1)) begin
                n_fail++;
                $display("FAIL lines_d1 k=%0d act=%h exp=%h", k, act1, expv(1));
            end
        end
    endtask

    task automatic test_palette();
        int cnt, first;
        cnt = 0;
        first = -1;
        for (int i = 0; i < 76800; i++) mem0[i] = 2'd0;
        mem0[5] = 2'd3;
        do_reset();
        for (int c = 1; c <= 1600; c++) begin
            @(negedge clk);
            n_tests++;
            if (act0 !== expv(0)) begin
                n_fail++;
                $display("FAIL palette_model k=%0d act=%h exp=%h", k, act0, expv(0));
            end
            if (rgb0 === 8'hE0) begin
                cnt++;
                if (first < 0) first = c;
                n_tests++;
                if (vo0 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL palette_video_on clk=%0d act=%b exp=1", c, vo0);
                end
            end
        end
        n_tests += 2;
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL palette_width act=%0d exp=4", cnt);
        end
        if (first != 22) begin
            n_fail++;
            $display("FAIL palette_start act=%0d exp=22", first);
        end
    endtask

    task automatic test_frames();
        int pulses, high, p0, p1, amax;
        logic prev;
        pulses = 0; high = 0; p0 = -1; p1 = -1; amax = 0; prev = 1'b0;
        for (int i = 0; i < 48; i++) mem1[i] = 2'($urandom);
        do_reset();
        for (int c = 1; c <= 1700; c++) begin
            @(negedge clk);
            n_tests++;
            if (act1 !== expv(1)) begin
                n_fail++;
                $display("FAIL frames_model k=%0d act=%h exp=%h", k, act1, expv(1));
            end
            if (int'(a1) > amax) amax = int'(a1);
            if (ft1 === 1'b1) begin
                high++;
                if (!prev) begin
                    pulses++;
                    if (p0 < 0) p0 = c; else if (p1 < 0) p1 = c;
                end
            end
            prev = ft1;
        end
        n_tests += 5;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL frame_tick_count act=%0d exp=2", pulses);
        end
        if (high != 2) begin
            n_fail++;
            $display("FAIL frame_tick_width act=%0d exp=2", high);
        end
        if (p0 != 576) begin
            n_fail++;
            $display("FAIL frame_tick_first act=%0d exp=576", p0);
        end
        if (p1 - p0 != 816) begin
            n_fail++;
            $display("FAIL frame_tick_period act=%0d exp=816", p1 - p0);
        end
        if (amax != 47) begin
            n_fail++;
            $display("FAIL addr_max act=%0d exp=47", amax);
        end
    endtask

    task automatic test_mid_reset();
        int  waited;
        logic seen;
        waited = 0;
        seen = 1'b0;
        for (int i = 0; i < 48; i++) mem1[i] = 2'($urandom);
        do_reset();
        while (k != 7 * 24 + 10 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (waited >= 1000) begin
            n_fail++;
            $display("FAIL mid_reset_wait act=%0d exp=%0d", k, 7 * 24 + 10);
        end
        reset_n = 1'b0;
        #1;
        n_tests += 2;
        if (act1 !== RST_V) begin
            n_fail++;
            $display("FAIL mid_reset_async_d1 act=%h exp=%h", act1, RST_V);
        end
        if (act0 !== RST_V) begin
            n_fail++;
            $display("FAIL mid_reset_async_d0 act=%h exp=%h", act0, RST_V);
        end
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (act1 !== RST_V) begin
                n_fail++;
                $display("FAIL mid_reset_hold act=%h exp=%h", act1, RST_V);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (a1 !== 6'd0) begin
            n_fail++;
            $display("FAIL mid_reset_addr0 act=%0d exp=0", a1);
        end
        repeat (900) begin
            @(negedge clk);
            n_tests++;
            if (act1 !== expv(1)) begin
                n_fail++;
                $display("FAIL mid_reset_model k=%0d act=%h exp=%h", k, act1, expv(1));
            end
            if (k == 1 && !seen) begin
                seen = 1'b1;
                n_tests++;
                if (rgb1 !== pal(mem1[0])) begin
                    n_fail++;
                    $display("FAIL mid_reset_rgb0 act=%h exp=%h", rgb1, pal(mem1[0]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_lines();
        test_palette();
        test_frames();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Read-side engine for the game's 2-bit-per-pixel frame buffer.
- Generates 640x480@60 VGA timing from the 50 MHz system clock.
- Drives the read address of the dual-port frame-buffer RAM, reading each 320x240 buffer pixel as a 2x2 screen block.
- Decodes returned pixels through a fixed palette to 8-bit RGB, with sync aligned to pixel data.
- Also emits a per-frame tick so game logic knows when to update the buffer through the write port.

Parameters:
- FB_W, 320: frame-buffer width in pixels; row pitch of the address.
- FB_H, 240: frame-buffer height in pixels.
- ADDR_WIDTH, 17: frame-buffer address width; must satisfy 2**ADDR_WIDTH >= FB_W*FB_H.
- DATA_WIDTH, 2: pixel width. Fixed at 2 for this palette.
- H_DISPLAY / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: horizontal timing in pixels.
- V_DISPLAY / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33: vertical timing in lines.

Ports:
- clk, in, 1: 50 MHz system clock, same clock as the RAM.
- reset_n, in, 1: asynchronous active-low reset.
- addr_b, out, ADDR_WIDTH: frame-buffer read address to the RAM read port.
- dout_b, in, DATA_WIDTH: RAM read data. Valid one clk after addr_b is presented, because the RAM registers the address.
- hsync, out, 1: horizontal sync, active-low.
- vsync, out, 1: vertical sync, active-low.
- video_on, out, 1: high while rgb carries an active pixel.
- rgb, out, 8: pixel colour, R[7:5] G[4:2] B[1:0].
- frame_tick, out, 1: one-clk pulse when the display enters vertical blanking.

Behaviour:
- Reset (async, reset_n=0): all internal counters and registers = 0, p_tick = 0, addr_b = 0, hsync = 1, vsync = 1, video_on = 0, rgb = 0, frame_tick = 0.
- Pixel tick: internal p_tick toggles every clk. First p_tick=1 occurs on the 2nd rising edge after reset release. All counter and output updates are qualified by p_tick=1.
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..524, and wraps to 0.
- Row base register row_base, updated on p_tick when h_cnt=799:
  - If v_cnt=524: row_base <= 0.
  - Else if v_cnt[0]=1 and v_cnt < V_DISPLAY-1: row_base <= row_base + FB_W.
  - Else unchanged.
  - Accumulator only; no multiplier.
- Address (combinational from registered state):
  - addr_b = row_base + (h_cnt>>1) when h_cnt < H_DISPLAY and v_cnt < V_DISPLAY.
  - Otherwise addr_b = row_base.
  - addr_b never exceeds FB_W*FB_H-1.
- Timing chain: counters update at a p_tick edge. The RAM captures addr_b at the following non-tick edge. dout_b is then stable at the next p_tick edge.
- Output registers, loaded on p_tick (values are those of the counter state just ended, so all outputs lag the counters by exactly one pixel period and are mutually aligned):
  - video_on <= (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
  - hsync <= !(h_cnt in [656,751]).
  - vsync <= !(v_cnt in [490,491]).
  - rgb <= active ? palette(dout_b) : 0.
- Palette: 00 -> 0x00 (black), 01 -> 0xFF (white), 10 -> 0x1C (green), 11 -> 0xE0 (red).
- frame_tick: high for exactly one clk, on the p_tick edge where v_cnt goes 479 -> 480 (at h_cnt wrap). Low otherwise.
- Reset mid-frame: all state clears immediately; scanout restarts at pixel (0,0) with row_base = 0. No partial-frame recovery.

Test Plan:
- Reset: hold reset_n=0 with random dout_b -> hsync=1, vsync=1, rgb=0, video_on=0, frame_tick=0, addr_b=0; unchanged across 10 clks.
- First lines: RAM model preloaded with addr[1:0]; observe addr_b during v_cnt=0 -> sequence 0,0,1,1,...,319,319. v_cnt=1 repeats 0..319. v_cnt=2 starts at 320. v_cnt=479 ends at 76799.
- Latency/palette: RAM word 5 = 2'b11, others 0 -> rgb=0xE0 for exactly 4 clks (screen x=10,11, one pixel late). video_on is high through the same period.
- Sync timing: count p_ticks -> hsync low for 96 pixels beginning 656 pixels after video_on rises; line period 800. vsync low for 2 lines (1600 p_ticks); frame period 420000 p_ticks.
- Frame tick: run 2 frames -> frame_tick pulses exactly twice, 840000 clks apart, each 1 clk wide, immediately after the last active line.
- Mid-frame reset: assert reset_n=0 for 3 clks at v_cnt=200, h_cnt=300 -> outputs return to reset values at once; after release the first active address is 0 and rgb matches word 0.
